mem_ctl: RTL

Data-memory controller directly downstream of the CPU core's memory port. Accepts single-cycle read/write requests (address, write data, strobes) from the core and runs them against an external asynchronous 16-bit SRAM with a fixed, parameterised number of wait states. Returns read data with the busy/ready handshake the core's decoder uses to stall.

---
 rtl/mem_ctl_pkg.sv | 23 ++
 rtl/mem_ctl.sv | 112 +++++++++++
 2 files changed

// File: rtl/mem_ctl_pkg.sv
// Shared types for the SRAM data-memory controller: FSM state encoding,
// operation type and wait-counter width.
package mem_ctl_pkg;

    // Controller phases; the 2-bit encoding is fixed so that state dumps
    // from older tooling line up.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Operation latched at request time.
    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    // Wait-state down-counter width (covers WAIT_STATES 0..15).
    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_ctl.sv
// Data-memory controller between the core memory port and an asynchronous
// 16-bit SRAM. Each request runs SETUP -> ACCESS (WAIT_STATES+1 cycles) ->
// DONE. All SRAM strobes and core handshake outputs are decoded from
// registered state only, so no core input reaches an output combinationally.
module mem_ctl #(
    parameter int WAIT_STATES = 2,
    parameter int ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       cpu_addr,
    input  logic [15:0]       cpu_wdata,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    output logic [15:0]       cpu_rdata,
    output logic              cpu_busy,
    output logic              cpu_ready,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [15:0]       sram_dq_in,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);
    import mem_ctl_pkg::*;

    localparam logic [CNT_W-1:0] WS_INIT = CNT_W'(WAIT_STATES);

    state_t             state_q, state_d;
    op_t                op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [15:0]        wdata_q, wdata_d;
    logic [15:0]        rdata_q, rdata_d;

    // Next-state logic: request capture in IDLE, wait counting in ACCESS,
    // read data capture on the edge that ends the last ACCESS cycle.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                // Write wins when both strobes are raised together.
                if (cpu_rd || cpu_wr) begin
                    state_d = SETUP;
                    op_d    = cpu_wr ? OP_WR : OP_RD;
                    addr_d  = cpu_addr[ADDR_W-1:0];
                    wdata_d = cpu_wdata;
                end
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = WS_INIT;
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    if (op_q == OP_RD) begin
                        rdata_d = sram_dq_in;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                // Strobes here are deliberately ignored; the core re-issues
                // only after seeing ready.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous active-low reset; a reset mid-access
    // abandons the transaction and drops every strobe on the next cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            op_q    <= OP_RD;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Output decode from registered state only. Write data stays driven
    // through DONE for hold time; we_n is only low inside ACCESS, where
    // dq_oe is already high, and oe_n/we_n are exclusive by op type.
    assign cpu_rdata   = rdata_q;
    assign cpu_busy    = (state_q == SETUP) || (state_q == ACCESS);
    assign cpu_ready   = (state_q == DONE);
    assign sram_addr   = addr_q;
    assign sram_dq_out = wdata_q;
    assign sram_ce_n   = !((state_q == SETUP) || (state_q == ACCESS));
    assign sram_oe_n   = !((state_q == ACCESS) && (op_q == OP_RD));
    assign sram_we_n   = !((state_q == ACCESS) && (op_q == OP_WR));
    assign sram_dq_oe  = (op_q == OP_WR) && (state_q != IDLE);

endmodule
